// File: rtl/iterative_shift_controller.sv
// -----------------------------------------------------------------------------
// iterative_shift_controller
//
// Purpose:
//    Shifts an N-bit operand left or right (logical or arithmetic) by a total
//    distance in_amt. The shift is spread over several clock cycles: each
//    SHIFT cycle moves the data at most STEP bit positions. The result is
//    presented with a valid/ready handshake.
//
// Parameters:
//    N     operand/result width in bits (N >= 2)
//    STEP  maximum shift distance applied per SHIFT cycle (1 <= STEP <= N)
//    AW    amount width, $clog2(N)+1, so the amount range includes N
//
// Ports:
//    clk        input   rising-edge clock
//    rst        input   asynchronous reset, active low
//    in_valid   input   request carries a valid operand
//    in_ready   output  block accepts a request this cycle (IDLE)
//    in_a       input   N-bit unsigned operand
//    in_amt     input   AW-bit total shift distance
//    in_dir     input   0 = left, 1 = right
//    in_arith   input   1 = right shift fills with operand MSB
//    out_valid  output  out_res holds a completed result (DONE)
//    out_ready  input   consumer takes the result this cycle
//    out_res    output  N-bit shifted result (always the data register)
//    busy       output  high in SHIFT or DONE
// -----------------------------------------------------------------------------
module iterative_shift_controller #(
   parameter int N    = 8,
   parameter int STEP = 3,
   localparam int AW  = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_a,
   input  logic [AW-1:0] in_amt,
   input  logic          in_dir,
   input  logic          in_arith,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_res,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

   state_t        r_state;
   state_t        w_next;
   logic [N-1:0]  r_data;
   logic [AW-1:0] r_rem;
   logic          r_dir;
   logic          r_arith;

   logic          w_accept;
   logic [AW-1:0] w_d;
   logic [N-1:0]  w_shifted;

   assign w_accept = (r_state == IDLE) && in_valid;

   // Distance covered this cycle: the full STEP, or whatever is left over.
   assign w_d = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;

   // One partial shift of the data register. Because w_d never exceeds N,
   // amounts >= N simply keep stepping until the register is fully flushed
   // to zero or to copies of the MSB.
   always_comb begin
      w_shifted = r_data;
      if (!r_dir) begin
         w_shifted = r_data << w_d;
      end else if (r_arith) begin
         w_shifted = $signed(r_data) >>> w_d;
      end else begin
         w_shifted = r_data >> w_d;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and handshake outputs, all decoded from the state.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next = (in_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (r_rem == w_d) begin
               w_next = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Datapath: capture the request on accept, then walk the remaining
   // distance down one partial shift per SHIFT cycle. The register is left
   // untouched in DONE and IDLE so the result stays on out_res.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_rem   <= '0;
         r_dir   <= 1'b0;
         r_arith <= 1'b0;
      end else if (w_accept) begin
         r_data  <= in_a;
         r_rem   <= in_amt;
         r_dir   <= in_dir;
         r_arith <= in_arith;
      end else if (r_state == SHIFT) begin
         r_data <= w_shifted;
         r_rem  <= r_rem - w_d;
      end
   end

   assign out_res = r_data;

endmodule

// File: tb/tb_iterative_shift_controller.sv
// -----------------------------------------------------------------------------
// tb_iterative_shift_controller
//
// Purpose:
//    Self-checking bench for iterative_shift_controller with N=8, STEP=3.
//    A behavioural model computes each result as one whole shift of the
//    operand and the completion time as ceil(amt/STEP); a compare process
//    checks the DUT against it on every falling edge. Directed operations
//    additionally check hand-computed literal results and latencies.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_iterative_shift_controller;

   localparam int N    = 8;
   localparam int STEP = 3;
   localparam int AW   = $clog2(N) + 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_a;
   logic [AW-1:0] in_amt;
   logic          in_dir;
   logic          in_arith;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_res;
   logic          busy;

   int passCount  = 0;
   int checkCount = 0;

   iterative_shift_controller #(.N(N), .STEP(STEP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .in_arith  (in_arith),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result: one combinational shift by the whole amount.
   function automatic logic [N-1:0] refShift(input logic [N-1:0] a,
                                             input logic [AW-1:0] amt,
                                             input logic dir,
                                             input logic arith);
      if (!dir) return a << amt;
      if (arith) return $signed(a) >>> amt;
      return a >> amt;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s got %0h expected %0h at %0t", name, actual,
                  expected, $time);
      end
   endtask

   // Model: phase 0 = waiting for a request, 1 = working, 2 = result held.
   int            mPhase;
   int            mLeft;
   logic [N-1:0]  mRes;

   // Model update follows the spec-level behaviour: result known at accept,
   // available ceil(amt/STEP) edges later, held until taken.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mPhase <= 0;
         mLeft  <= 0;
         mRes   <= '0;
      end else begin
         case (mPhase)
            0: if (in_valid) begin
               mRes <= refShift(in_a, in_amt, in_dir, in_arith);
               mLeft <= (int'(in_amt) + STEP - 1) / STEP;
               mPhase <= (in_amt == 0) ? 2 : 1;
            end
            1: begin
               mLeft <= mLeft - 1;
               if (mLeft == 1) mPhase <= 2;
            end
            default: if (out_ready) mPhase <= 0;
         endcase
      end
   end

   // Every-cycle comparison against the model on the falling edge. The
   // intermediate data register value while working is not checked here.
   always @(negedge clk) begin
      checkOutput("cmp_in_ready", 32'(in_ready), 32'(mPhase == 0));
      checkOutput("cmp_busy", 32'(busy), 32'(mPhase != 0));
      checkOutput("cmp_out_valid", 32'(out_valid), 32'(mPhase == 2));
      if (mPhase != 1) checkOutput("cmp_out_res", 32'(out_res), 32'(mRes));
   end

   // Issue one request, step through its latency checking busy/valid, then
   // check the literal result and hand it off.
   task automatic applyStimulus(input string name, input logic [N-1:0] a,
                                input logic [AW-1:0] amt, input logic dir,
                                input logic arith, input logic [N-1:0] expRes,
                                input int expK);
      in_valid = 1'b1;
      in_a     = a;
      in_amt   = amt;
      in_dir   = dir;
      in_arith = arith;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < expK; i++) begin
         checkOutput({name, "_wait_valid"}, 32'(out_valid), 32'd0);
         checkOutput({name, "_wait_busy"}, 32'(busy), 32'd1);
         checkOutput({name, "_wait_in_ready"}, 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, "_res"}, 32'(out_res), 32'(expRes));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({name, "_back_idle"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [N-1:0] held;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_amt    = '0;
      in_dir    = 1'b0;
      in_arith  = 1'b0;
      out_ready = 1'b0;

      // Reset state.
      #12;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_out_res", 32'(out_res), 32'd0);

      // Pin the model's reference shift to hand-computed values.
      checkOutput("model_left", 32'(refShift(8'hB6, 4'd3, 1'b0, 1'b0)), 32'hB0);
      checkOutput("model_arith", 32'(refShift(8'h80, 4'd5, 1'b1, 1'b1)), 32'hFC);
      checkOutput("model_big", 32'(refShift(8'hFF, 4'd8, 1'b0, 1'b0)), 32'h00);

      // Release reset between edges and request at once: first edge accepts.
      @(posedge clk); #1;
      rst = 1'b1;
      applyStimulus("left3", 8'hB6, 4'd3, 1'b0, 1'b0, 8'hB0, 1);
      applyStimulus("rlog7", 8'hFF, 4'd7, 1'b1, 1'b0, 8'h01, 3);
      applyStimulus("rari5", 8'h80, 4'd5, 1'b1, 1'b1, 8'hFC, 2);
      applyStimulus("zero", 8'h5A, 4'd0, 1'b0, 1'b0, 8'h5A, 0);
      applyStimulus("left8", 8'hFF, 4'd8, 1'b0, 1'b0, 8'h00, 3);
      applyStimulus("left6", 8'h01, 4'd6, 1'b0, 1'b0, 8'h40, 2);
      applyStimulus("rari15", 8'h80, 4'd15, 1'b1, 1'b1, 8'hFF, 5);
      applyStimulus("rlog9", 8'hC3, 4'd9, 1'b1, 1'b0, 8'h00, 3);
      applyStimulus("rari2pos", 8'h40, 4'd2, 1'b1, 1'b1, 8'h10, 1);
      applyStimulus("leftarith", 8'h81, 4'd1, 1'b0, 1'b1, 8'h02, 1);

      // Stall in DONE with a competing request present.
      in_valid = 1'b1;
      in_a     = 8'h3C;
      in_amt   = 4'd1;
      in_dir   = 1'b0;
      in_arith = 1'b0;
      @(posedge clk); #1;
      in_a = 8'hE7;
      in_amt = 4'd2;
      @(posedge clk); #1;
      checkOutput("stall_reached_done", 32'(out_valid), 32'd1);
      held = out_res;
      checkOutput("stall_res", 32'(held), 32'h78);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checkOutput("stall_stable", 32'(out_res), 32'h78);
         checkOutput("stall_no_accept", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("stall_release_idle", 32'(in_ready), 32'd1);
      checkOutput("stall_release_valid", 32'(out_valid), 32'd0);

      // Reset during SHIFT aborts the operation immediately.
      in_valid = 1'b1;
      in_a     = 8'hFF;
      in_amt   = 4'd7;
      in_dir   = 1'b0;
      in_arith = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_out_res", 32'(out_res), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("abort_no_stale", 32'(out_valid), 32'd0);
         checkOutput("abort_res_zero", 32'(out_res), 32'd0);
      end
      applyStimulus("after_abort", 8'h96, 4'd4, 1'b1, 1'b1, 8'hF9, 2);

      @(posedge clk); #1;
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
